// File: rtl/cram_load_ctl_if.sv
// rtl/cram_load_ctl_if.sv - CRAM port arbitration signals between EBOX, diag path and cram_mem
interface cram_load_ctl_if #(
    parameter int ADDR_W  = 12,
    parameter int SLICE_W = 28
);
    logic [ADDR_W-1:0]    CRADR;
    logic                 eboxHalted;
    logic                 diagMode;
    logic                 diagLdAddr;
    logic                 diagLdData;
    logic                 diagWrite;
    logic                 diagRead;
    logic [1:0]           diagSel;
    logic [SLICE_W-1:0]   diagData;
    logic [SLICE_W-1:0]   diagRdData;
    logic                 diagOwn;
    logic                 diagBusy;
    logic                 diagDone;
    logic                 diagErr;
    logic                 eboxStopReq;
    logic [ADDR_W-1:0]    cramAddr;
    logic [3*SLICE_W-1:0] cramDin;
    logic                 cramWe;
    logic [3*SLICE_W-1:0] cramDout;

    modport master (
        output CRADR, eboxHalted, diagMode, diagLdAddr, diagLdData, diagWrite, diagRead,
               diagSel, diagData, cramDout,
        input  diagRdData, diagOwn, diagBusy, diagDone, diagErr, eboxStopReq,
               cramAddr, cramDin, cramWe
    );

    modport slave (
        input  CRADR, eboxHalted, diagMode, diagLdAddr, diagLdData, diagWrite, diagRead,
               diagSel, diagData, cramDout,
        output diagRdData, diagOwn, diagBusy, diagDone, diagErr, eboxStopReq,
               cramAddr, cramDin, cramWe
    );
endinterface

// File: rtl/cram_load_ctl.sv
// rtl/cram_load_ctl.sv - CRAM single-port owner: EBOX halt handshake, diag slice load, write and read-back
module cram_load_ctl #(
    parameter int ADDR_W  = 12,
    parameter int WORDS   = 2048,
    parameter int SLICE_W = 28,
    parameter int RD_LAT  = 1
) (
    input logic            eboxClk,
    input logic            eboxReset_n,
    cram_load_ctl_if.slave bus
);
    localparam int WORD_W = 3 * SLICE_W;
    localparam int CNT_W  = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [ADDR_W:0]   WORDS_L  = (ADDR_W + 1)'(WORDS);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  RD_LAST  = CNT_W'(RD_LAT);

    typedef enum logic [2:0] {RUN, STOPPING, OWN, WRITE, READ, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   stage_q, stage_d;
    logic [WORD_W-1:0]   rdbk_q, rdbk_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [3:0]          strobes;
    logic                any_strobe, multi_strobe, addr_ok;
    logic [SLICE_W-1:0]  rd_slice;

    assign strobes      = {bus.diagLdAddr, bus.diagLdData, bus.diagWrite, bus.diagRead};
    assign any_strobe   = |strobes;
    assign multi_strobe = (strobes & (strobes - 4'd1)) != 4'd0;
    assign addr_ok      = {1'b0, bus.diagData[ADDR_W-1:0]} < WORDS_L;

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            state_q <= RUN;
            addr_q  <= '0;
            stage_q <= '0;
            rdbk_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            stage_q <= stage_d;
            rdbk_q  <= rdbk_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        stage_d = stage_q;
        rdbk_d  = rdbk_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        // Any strobe outside OWN is dropped and flagged, whatever the state does next.
        if (state_q != OWN && any_strobe) err_d = 1'b1;
        case (state_q)
            RUN: begin
                if (bus.diagMode) state_d = STOPPING;
            end
            STOPPING: begin
                if (!bus.diagMode)       state_d = RUN;
                else if (bus.eboxHalted) state_d = OWN;
            end
            OWN: begin
                if (multi_strobe) begin
                    err_d = 1'b1;
                end else if (bus.diagLdAddr) begin
                    if (addr_ok) addr_d = bus.diagData[ADDR_W-1:0];
                    else         err_d  = 1'b1;
                end else if (bus.diagLdData) begin
                    case (bus.diagSel)
                        2'd0:    stage_d[WORD_W-1 -: SLICE_W]           = bus.diagData;
                        2'd1:    stage_d[WORD_W-1-SLICE_W -: SLICE_W]   = bus.diagData;
                        2'd2:    stage_d[SLICE_W-1:0]                   = bus.diagData;
                        default: err_d = 1'b1;
                    endcase
                end else if (bus.diagWrite) begin
                    state_d = WRITE;
                end else if (bus.diagRead) begin
                    state_d = READ;
                    cnt_d   = '0;
                end else if (!bus.diagMode) begin
                    state_d = RUN;
                end
            end
            WRITE: begin
                state_d = DONE;
            end
            READ: begin
                // Address is held one cycle to be sampled, then RD_LAT more until douta is valid.
                if (cnt_q == RD_LAST) begin
                    rdbk_d  = bus.cramDout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                addr_d  = (addr_q == LAST_A) ? '0 : addr_q + 1'b1;
                state_d = bus.diagMode ? OWN : RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        rd_slice = '0;
        case (bus.diagSel)
            2'd0:    rd_slice = rdbk_q[WORD_W-1 -: SLICE_W];
            2'd1:    rd_slice = rdbk_q[WORD_W-1-SLICE_W -: SLICE_W];
            2'd2:    rd_slice = rdbk_q[SLICE_W-1:0];
            default: rd_slice = '0;
        endcase
    end

    assign bus.diagOwn     = (state_q == OWN) || (state_q == WRITE) ||
                             (state_q == READ) || (state_q == DONE);
    assign bus.diagBusy    = (state_q == WRITE) || (state_q == READ) || (state_q == DONE);
    assign bus.diagDone    = (state_q == DONE);
    assign bus.diagErr     = err_q;
    assign bus.eboxStopReq = (state_q != RUN);
    assign bus.cramWe      = (state_q == WRITE);
    assign bus.cramAddr    = bus.diagOwn ? addr_q : bus.CRADR;
    assign bus.cramDin     = stage_q;
    assign bus.diagRdData  = rd_slice;
endmodule

// File: tb/tb_cram_load_ctl.sv
// tb/tb_cram_load_ctl.sv - randomized scoreboard bench for cram_load_ctl with a CRAM model and reference store
module tb_cram_load_ctl;
    localparam logic [3:0] S_LA = 4'b1000, S_LD = 4'b0100, S_WR = 4'b0010, S_RD = 4'b0001;

    typedef struct {
        logic [11:0] addr;
        logic [83:0] din;
    } we_t;
    typedef struct {
        bit          rd;
        logic [83:0] word;
        logic [11:0] addr;
    } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cram_load_ctl_if #(.ADDR_W(12), .SLICE_W(28)) bus ();

    cram_load_ctl #(.ADDR_W(12), .WORDS(2048), .SLICE_W(28), .RD_LAT(1)) dut (
        .eboxClk     (clk),
        .eboxReset_n (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [83:0] mem     [0:2047];
    logic [83:0] ref_mem [0:2047];
    logic [83:0] ref_stage;
    logic [11:0] ref_addr;
    bit          owned;
    we_t         exp_we[$];
    done_t       exp_done[$];
    int          checks = 0;
    int          errs   = 0;
    int          act_err = 0;
    int          exp_err = 0;

    // One-cycle-latency single-port RAM standing in for cram_mem.
    always @(posedge clk) begin
        if (bus.cramWe) mem[bus.cramAddr[10:0]] <= bus.cramDin;
        bus.cramDout <= mem[bus.cramAddr[10:0]];
    end

    task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [27:0] slc(input logic [83:0] w, input int k);
        return w[83-28*k -: 28];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.diagErr) act_err++;
            if (bus.cramWe) begin
                chk("we_while_owned", 84'(bus.diagOwn), 84'(1));
                if (exp_we.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL unexpected_we: got write at %o expected none", bus.cramAddr);
                end else begin
                    we_t e;
                    e = exp_we.pop_front();
                    chk("we_addr", 84'(bus.cramAddr), 84'(e.addr));
                    chk("we_din", bus.cramDin, e.din);
                end
            end
            if (bus.diagDone) begin
                if (exp_done.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL unexpected_done: got diagDone expected none");
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("done_addr", 84'(bus.cramAddr), 84'(d.addr));
                    chk("done_busy", 84'(bus.diagBusy), 84'(1));
                    if (d.rd) chk("rd_data", 84'(bus.diagRdData), 84'(slc(d.word, int'(bus.diagSel))));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [3:0] strb, input logic [27:0] data, input logic [1:0] sel, input bit drop);
        bit bad;
        int n;
        int lat;
        bad = !owned || ($countones(strb) != 1) || (strb == S_LD && sel == 2'd3) ||
              (strb == S_LA && data[11:0] >= 12'd2048);
        {bus.diagLdAddr, bus.diagLdData, bus.diagWrite, bus.diagRead} = strb;
        bus.diagData = data;
        bus.diagSel  = sel;
        if (bad) begin
            exp_err++;
        end else if (strb == S_LA) begin
            ref_addr = data[11:0];
        end else if (strb == S_LD) begin
            ref_stage[83-28*int'(sel) -: 28] = data;
        end else if (strb == S_WR) begin
            exp_we.push_back('{ref_addr, ref_stage});
            exp_done.push_back('{1'b0, ref_stage, ref_addr});
            ref_mem[ref_addr[10:0]] = ref_stage;
        end else begin
            exp_done.push_back('{1'b1, ref_mem[ref_addr[10:0]], ref_addr});
        end
        tick();
        {bus.diagLdAddr, bus.diagLdData, bus.diagWrite, bus.diagRead} = 4'b0;
        if (drop) bus.diagMode = 1'b0;
        chk("err_pulse", 84'(bus.diagErr), 84'(bad));
        if (!bad && (strb == S_WR || strb == S_RD)) begin
            lat = (strb == S_WR) ? 2 : 3;
            n = 1;
            while (!bus.diagDone && n < 20) begin
                tick();
                n++;
            end
            chk("done_latency", 84'(n), 84'(lat));
            tick();
            ref_addr = (ref_addr == 12'd2047) ? 12'd0 : ref_addr + 12'd1;
            if (drop) owned = 1'b0;
        end
        if (owned) chk("addr_reg", 84'(bus.cramAddr), 84'(ref_addr));
        else       chk("addr_ebox", 84'(bus.cramAddr), 84'(bus.CRADR));
    endtask

    task automatic acquire();
        bus.diagMode   = 1'b1;
        bus.eboxHalted = 1'b0;
        repeat (5) tick();
        chk("stopreq_waiting", 84'(bus.eboxStopReq), 84'(1));
        chk("own_waiting", 84'(bus.diagOwn), 84'(0));
        bus.eboxHalted = 1'b1;
        tick();
        chk("own_granted", 84'(bus.diagOwn), 84'(1));
        owned = 1'b1;
    endtask

    task automatic release_own();
        bus.diagMode = 1'b0;
        tick();
        chk("own_released", 84'(bus.diagOwn), 84'(0));
        chk("stopreq_released", 84'(bus.eboxStopReq), 84'(0));
        bus.eboxHalted = 1'b0;
        owned = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  strb;
        logic [27:0] data;
        int          r;
        int          i;
        int          j;
        for (int k = 0; k < 2048; k++) begin
            mem[k] = '0;
            ref_mem[k] = '0;
        end
        ref_stage = '0;
        ref_addr = '0;
        owned = 1'b0;
        bus.CRADR = 12'o1234;
        bus.eboxHalted = 1'b0;
        bus.diagMode = 1'b0;
        {bus.diagLdAddr, bus.diagLdData, bus.diagWrite, bus.diagRead} = 4'b0;
        bus.diagSel = 2'd0;
        bus.diagData = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        chk("reset_cramaddr", 84'(bus.cramAddr), 84'(12'o1234));
        chk("reset_we", 84'(bus.cramWe), 84'(0));
        chk("reset_own", 84'(bus.diagOwn), 84'(0));
        chk("reset_stopreq", 84'(bus.eboxStopReq), 84'(0));
        chk("reset_busy", 84'(bus.diagBusy), 84'(0));
        chk("reset_done", 84'(bus.diagDone), 84'(0));
        chk("reset_err", 84'(bus.diagErr), 84'(0));
        chk("reset_din", bus.cramDin, 84'(0));
        chk("reset_rddata", 84'(bus.diagRdData), 84'(0));

        acquire();
        do_op(S_LA, 28'o100, 2'd0, 1'b0);
        do_op(S_LD, 28'h1234567, 2'd0, 1'b0);
        do_op(S_LD, 28'h89ABCDE, 2'd1, 1'b0);
        do_op(S_LD, 28'h0F0F0F0, 2'd2, 1'b0);
        do_op(S_WR, 28'h0, 2'd0, 1'b0);
        do_op(S_LA, 28'o100, 2'd0, 1'b0);
        do_op(S_RD, 28'h0, 2'd1, 1'b0);
        bus.diagSel = 2'd0; #1 chk("rb_slice0", 84'(bus.diagRdData), 84'(28'h1234567));
        bus.diagSel = 2'd1; #1 chk("rb_slice1", 84'(bus.diagRdData), 84'(28'h89ABCDE));
        bus.diagSel = 2'd2; #1 chk("rb_slice2", 84'(bus.diagRdData), 84'(28'h0F0F0F0));
        chk("rd_addr_inc", 84'(bus.cramAddr), 84'(12'o101));

        do_op(S_LA, 28'o3777, 2'd0, 1'b0);
        do_op(S_WR, 28'h0, 2'd0, 1'b0);
        chk("addr_wrap", 84'(bus.cramAddr), 84'(0));
        do_op(S_LA, 28'o4000, 2'd0, 1'b0);
        chk("addr_kept_on_bad_ld", 84'(bus.cramAddr), 84'(0));
        do_op(S_LD | S_WR, 28'h5555555, 2'd0, 1'b0);
        do_op(S_LD, 28'h7777777, 2'd3, 1'b0);

        do_op(S_LA, 28'o100, 2'd0, 1'b0);
        do_op(S_RD, 28'h0, 2'd2, 1'b1);
        chk("run_after_drop_own", 84'(bus.diagOwn), 84'(0));
        chk("run_after_drop_stop", 84'(bus.eboxStopReq), 84'(0));
        bus.eboxHalted = 1'b0;
        do_op(S_WR, 28'h0, 2'd0, 1'b0);
        do_op(S_LA, 28'o5, 2'd0, 1'b0);

        acquire();
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 10);
            data = 28'($urandom);
            if (r <= 2) begin
                do_op(S_LD, data, 2'($urandom_range(0, 3)), 1'b0);
            end else if (r <= 4) begin
                if ($urandom_range(0, 3) != 0)
                    data[11:0] = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 15))
                                                             : 12'($urandom_range(2040, 2047));
                do_op(S_LA, data, 2'd0, 1'b0);
            end else if (r <= 6) begin
                do_op(S_WR, data, 2'd0, 1'b0);
            end else if (r <= 8) begin
                do_op(S_RD, data, 2'($urandom_range(0, 2)), 1'b0);
            end else if (r == 9) begin
                i = $urandom_range(0, 3);
                j = (i + 1 + $urandom_range(0, 2)) % 4;
                strb = 4'((1 << i) | (1 << j));
                do_op(strb, data, 2'($urandom_range(0, 2)), 1'b0);
            end else begin
                release_own();
                acquire();
            end
        end

        do_op(S_LD, 28'hABCDEF1, 2'd1, 1'b0);
        bus.diagWrite = 1'b1;
        tick();
        bus.diagWrite = 1'b0;
        chk("pre_reset_we", 84'(bus.cramWe), 84'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_we", 84'(bus.cramWe), 84'(0));
        chk("async_reset_own", 84'(bus.diagOwn), 84'(0));
        chk("async_reset_stop", 84'(bus.eboxStopReq), 84'(0));
        chk("async_reset_rddata", 84'(bus.diagRdData), 84'(0));
        exp_we.delete();
        exp_done.delete();
        ref_stage = '0;
        ref_addr = '0;
        owned = 1'b0;
        bus.diagMode = 1'b0;
        bus.eboxHalted = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        acquire();
        do_op(S_LA, 28'o7, 2'd0, 1'b0);
        do_op(S_WR, 28'h0, 2'd0, 1'b0);
        do_op(S_LA, 28'o7, 2'd0, 1'b0);
        do_op(S_RD, 28'h0, 2'd1, 1'b0);
        release_own();
        repeat (2) tick();

        chk("err_count", 84'(act_err), 84'(exp_err));
        chk("we_queue_drained", 84'(exp_we.size()), 84'(0));
        chk("done_queue_drained", 84'(exp_done.size()), 84'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
